// File: rtl/disp_vram_reader.sv
// AXI4 read master that streams one frame of VRAM pixels into the display FIFO.
// One outstanding INCR burst at a time, issued only when the FIFO has room.
module disp_vram_reader #(
    parameter int ADDR_W    = 32,
    parameter int BURST_LEN = 128,
    parameter int H_PIXELS  = 640,
    parameter int V_LINES   = 480
) (
    input  logic              ACLK,
    input  logic              ARESETN,
    input  logic              DISP_ON,
    input  logic              AXI_START,
    input  logic [ADDR_W-1:0] DISPADDR,
    output logic              FIFO_WR,
    output logic [23:0]       FIFO_DIN,
    input  logic              FIFO_AFULL,
    output logic [ADDR_W-1:0] ARADDR,
    output logic [7:0]        ARLEN,
    output logic [2:0]        ARSIZE,
    output logic [1:0]        ARBURST,
    output logic              ARVALID,
    input  logic              ARREADY,
    input  logic [31:0]       RDATA,
    input  logic [1:0]        RRESP,
    input  logic              RLAST,
    input  logic              RVALID,
    output logic              RREADY,
    output logic              BUSY,
    output logic              RD_ERR
);

    localparam int NBURST = (H_PIXELS * V_LINES) / BURST_LEN;
    localparam int CNT_W  = (NBURST > 1) ? $clog2(NBURST) : 1;
    localparam int OFF_W  = $clog2(BURST_LEN * 4);

    localparam logic [ADDR_W-1:0] LOW_MASK =
        ADDR_W'((64'd1 << OFF_W) - 64'd1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NBURST - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_ROOM,
        S_ADDR,
        S_DATA
    } state_t;

    state_t state_q, state_d;

    logic              start_meta_q, start_sync_q, start_prev_q;
    logic              don_meta_q, don_sync_q;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [CNT_W-1:0]  burst_cnt_q, burst_cnt_d;
    logic [ADDR_W-1:0] araddr_q, araddr_d;
    logic              arvalid_q, arvalid_d;
    logic              rready_q, rready_d;
    logic              fifo_wr_q, fifo_wr_d;
    logic [23:0]       fifo_din_q, fifo_din_d;
    logic              busy_q, busy_d;
    logic              rd_err_q, rd_err_d;

    logic              start_pulse;
    logic              go;
    logic              beat;
    logic              last_burst;
    logic [ADDR_W-1:0] burst_off;
    logic [7:0]        rdata_unused;

    assign start_pulse  = start_sync_q & ~start_prev_q;
    assign go           = start_pulse & don_sync_q;
    assign beat         = RVALID & rready_q;
    assign last_burst   = (burst_cnt_q == LAST_CNT);
    assign burst_off    = ADDR_W'(burst_cnt_q) << OFF_W;
    assign rdata_unused = RDATA[31:24];

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q      <= S_IDLE;
            start_meta_q <= 1'b0;
            start_sync_q <= 1'b0;
            start_prev_q <= 1'b0;
            don_meta_q   <= 1'b0;
            don_sync_q   <= 1'b0;
            base_q       <= '0;
            burst_cnt_q  <= '0;
            araddr_q     <= '0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            fifo_wr_q    <= 1'b0;
            fifo_din_q   <= '0;
            busy_q       <= 1'b0;
            rd_err_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            start_meta_q <= AXI_START;
            start_sync_q <= start_meta_q;
            start_prev_q <= start_sync_q;
            don_meta_q   <= DISP_ON;
            don_sync_q   <= don_meta_q;
            base_q       <= base_d;
            burst_cnt_q  <= burst_cnt_d;
            araddr_q     <= araddr_d;
            arvalid_q    <= arvalid_d;
            rready_q     <= rready_d;
            fifo_wr_q    <= fifo_wr_d;
            fifo_din_q   <= fifo_din_d;
            busy_q       <= busy_d;
            rd_err_q     <= rd_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (go) state_d = S_WAIT_ROOM;
            end
            S_WAIT_ROOM: begin
                if (!FIFO_AFULL) state_d = S_ADDR;
            end
            S_ADDR: begin
                if (ARREADY) state_d = S_DATA;
            end
            S_DATA: begin
                if (beat && RLAST) begin
                    state_d = last_burst ? S_IDLE : S_WAIT_ROOM;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered: each *_d is the value the port shows next cycle.
    always_comb begin
        arvalid_d   = 1'b0;
        rready_d    = 1'b0;
        araddr_d    = araddr_q;
        base_d      = base_q;
        burst_cnt_d = burst_cnt_q;
        busy_d      = busy_q;
        fifo_wr_d   = beat;
        fifo_din_d  = beat ? RDATA[23:0] : fifo_din_q;
        rd_err_d    = rd_err_q | (beat & (RRESP != 2'b00));
        unique case (state_q)
            S_IDLE: begin
                if (go) begin
                    base_d      = DISPADDR & ~LOW_MASK;
                    burst_cnt_d = '0;
                    busy_d      = 1'b1;
                end
            end
            S_WAIT_ROOM: begin
                if (!FIFO_AFULL) begin
                    arvalid_d = 1'b1;
                    araddr_d  = base_q + burst_off;
                end
            end
            S_ADDR: begin
                arvalid_d = ~ARREADY;
                rready_d  = ARREADY;
            end
            S_DATA: begin
                rready_d = ~(beat & RLAST);
                if (beat && RLAST) begin
                    burst_cnt_d = burst_cnt_q + 1'b1;
                    if (last_burst) busy_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign ARADDR   = araddr_q;
    assign ARVALID  = arvalid_q;
    assign ARLEN    = 8'(BURST_LEN - 1);
    assign ARSIZE   = 3'b010;
    assign ARBURST  = 2'b01;
    assign RREADY   = rready_q;
    assign FIFO_WR  = fifo_wr_q;
    assign FIFO_DIN = fifo_din_q;
    assign BUSY     = busy_q;
    assign RD_ERR   = rd_err_q;

endmodule

// File: tb/tb_disp_vram_reader.sv
// Randomised bench for disp_vram_reader: a memory-backed AXI slave plus a
// frame-level model of the expected AR addresses, pixels and error flag.
`timescale 1ns/1ps
module tb_disp_vram_reader;

    localparam int AW     = 32;
    localparam int BL     = 8;
    localparam int HP     = 16;
    localparam int VL     = 4;
    localparam int NPIX   = HP * VL;
    localparam int NB     = NPIX / BL;
    localparam int STRIDE = BL * 4;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic          disp_on = 1'b0;
    logic          axi_start = 1'b0;
    logic [AW-1:0] dispaddr = '0;
    logic          fifo_wr;
    logic [23:0]   fifo_din;
    logic          fifo_afull = 1'b0;
    logic [AW-1:0] araddr;
    logic [7:0]    arlen;
    logic [2:0]    arsize;
    logic [1:0]    arburst;
    logic          arvalid;
    logic          arready = 1'b0;
    logic [31:0]   rdata = '0;
    logic [1:0]    rresp = '0;
    logic          rlast = 1'b0;
    logic          rvalid = 1'b0;
    logic          rready;
    logic          busy;
    logic          rd_err;

    always #5 aclk = ~aclk;

    disp_vram_reader #(
        .ADDR_W(AW), .BURST_LEN(BL), .H_PIXELS(HP), .V_LINES(VL)
    ) dut (
        .ACLK(aclk), .ARESETN(aresetn), .DISP_ON(disp_on),
        .AXI_START(axi_start), .DISPADDR(dispaddr),
        .FIFO_WR(fifo_wr), .FIFO_DIN(fifo_din), .FIFO_AFULL(fifo_afull),
        .ARADDR(araddr), .ARLEN(arlen), .ARSIZE(arsize), .ARBURST(arburst),
        .ARVALID(arvalid), .ARREADY(arready),
        .RDATA(rdata), .RRESP(rresp), .RLAST(rlast), .RVALID(rvalid),
        .RREADY(rready), .BUSY(busy), .RD_ERR(rd_err)
    );

    int checks = 0;
    int failures = 0;

    logic [AW-1:0] exp_ar[$];
    logic [23:0]   exp_pix[$];
    logic [AW-1:0] slv_q[$];
    int            slv_beat = 0;
    int            frame_beats_left = 0;
    int            frame_ar_idx = 0;
    int            wr_total = 0;
    int            ar_total = 0;

    bit rand_mode = 0;
    bit err_req = 0;
    bit err_model = 0;
    int stall_at = -1;
    int bp_at = -1;
    bit stall_done = 0;
    int stall_cnt = 0;
    int afull_cnt = 0;

    bit            ar_hs_p = 0, r_hs_p = 0, r_err_p = 0;
    bit            arv_p = 0, afull_p = 0, arwait_p = 0;
    logic [AW-1:0] araddr_p = '0;
    logic [AW-1:0] slv_a;
    logic [23:0]   px;

    bit            pin_cap = 0;
    logic [AW-1:0] pin_ar[2];
    logic [23:0]   pin_px[2];
    int            pin_nar = 0, pin_npx = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t",
                     name, act, exp, $time);
        end
    endtask

    // VRAM contents: a pure function of the word address.
    function automatic logic [23:0] mem_pix(input logic [AW-1:0] a);
        return a[25:2] ^ 24'hA5A5A5;
    endfunction

    task automatic push_frame(input logic [AW-1:0] base);
        logic [AW-1:0] b;
        b = base & ~AW'(STRIDE - 1);
        for (int k = 0; k < NB; k++) exp_ar.push_back(b + AW'(k * STRIDE));
        for (int i = 0; i < NPIX; i++) exp_pix.push_back(mem_pix(b + AW'(4 * i)));
        frame_beats_left += NPIX;
        frame_ar_idx = 0;
        stall_done = 0;
    endtask

    task automatic pulse_start();
        @(negedge aclk);
        axi_start = 1'b1;
        repeat (6) @(negedge aclk);
        axi_start = 1'b0;
        repeat (2) @(negedge aclk);
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while ((exp_pix.size() != 0 || exp_ar.size() != 0 || busy) && n < 5000) begin
            @(negedge aclk);
            n++;
        end
        chk(name, n < 5000, 1'b1);
        repeat (3) @(negedge aclk);
    endtask

    // Slave, stimulus for the AXI/FIFO side, and per-cycle comparison.
    initial begin
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                slv_q.delete();
                slv_beat = 0;
                rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; arready = 1'b0;
                ar_hs_p = 0; r_hs_p = 0; r_err_p = 0;
                arv_p = 0; arwait_p = 0; afull_p = 0;
                stall_cnt = 0; afull_cnt = 0; fifo_afull = 1'b0;
                continue;
            end

            chk("fifo_wr_on_beat", fifo_wr, r_hs_p);
            if (fifo_wr) begin
                wr_total++;
                chk("pix_pending", exp_pix.size() > 0, 1'b1);
                if (exp_pix.size() > 0) begin
                    px = exp_pix.pop_front();
                    chk("fifo_din", fifo_din, px);
                    if (pin_cap && pin_npx < 2) begin
                        pin_px[pin_npx] = fifo_din;
                        pin_npx++;
                    end
                end
            end

            if (r_hs_p) begin
                if (r_err_p) err_model = 1;
                frame_beats_left--;
                chk("busy_during_frame", busy, frame_beats_left != 0);
                slv_beat++;
                if (slv_beat == BL) begin
                    slv_beat = 0;
                    void'(slv_q.pop_front());
                end
            end
            chk("rd_err", rd_err, err_model);
            if (arwait_p) begin
                chk("arvalid_hold", arvalid, 1'b1);
                chk("araddr_hold", araddr, araddr_p);
            end
            if (arvalid && !arv_p) chk("arvalid_rise_afull", afull_p, 1'b0);

            if (stall_at >= 0 && !stall_done && arvalid && frame_ar_idx == stall_at) begin
                stall_cnt = 10;
                stall_done = 1;
            end
            if (stall_cnt > 0) begin
                arready = 1'b0;
                stall_cnt--;
            end else begin
                arready = rand_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
            end
            if (afull_cnt > 0) begin
                fifo_afull = 1'b1;
                afull_cnt--;
            end else begin
                fifo_afull = rand_mode ? ($urandom_range(0, 4) == 0) : 1'b0;
            end

            if (!(rvalid && !r_hs_p)) begin
                if (slv_q.size() > 0 && (!rand_mode || $urandom_range(0, 2) != 0)) begin
                    slv_a  = slv_q[0] + AW'(4 * slv_beat);
                    rvalid = 1'b1;
                    rdata  = {8'($urandom), mem_pix(slv_a)};
                    rlast  = (slv_beat == BL - 1);
                    rresp  = err_req ? 2'b10 : 2'b00;
                    err_req = 0;
                end else begin
                    rvalid = 1'b0;
                    rlast  = 1'b0;
                    rresp  = 2'b00;
                end
            end

            ar_hs_p = arvalid && arready;
            if (ar_hs_p) begin
                ar_total++;
                chk("ar_expected", exp_ar.size() > 0, 1'b1);
                if (exp_ar.size() > 0) chk("araddr", araddr, exp_ar.pop_front());
                chk("arlen", arlen, 64'(BL - 1));
                chk("arsize_arburst", {arsize, arburst}, 5'b010_01);
                if (pin_cap && pin_nar < 2) begin
                    pin_ar[pin_nar] = araddr;
                    pin_nar++;
                end
                slv_q.push_back(araddr);
                frame_ar_idx++;
                if (bp_at >= 0 && frame_ar_idx == bp_at) afull_cnt = 50;
            end
            r_hs_p   = rvalid && rready;
            r_err_p  = r_hs_p && (rresp != 2'b00);
            arwait_p = arvalid && !arready;
            araddr_p = araddr;
            arv_p    = arvalid;
            afull_p  = fifo_afull;
        end
    end

    initial begin
        int n;
        int ar_before;
        int wr_before;

        aresetn = 1'b0;
        repeat (3) @(negedge aclk);
        chk("rst_arvalid", arvalid, 1'b0);
        chk("rst_rready", rready, 1'b0);
        chk("rst_fifo_wr", fifo_wr, 1'b0);
        chk("rst_fifo_din", fifo_din, 24'h0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_rd_err", rd_err, 1'b0);
        chk("rst_araddr", araddr, 32'h0);
        aresetn = 1'b1;
        repeat (10) @(negedge aclk);
        chk("idle_no_arvalid", arvalid, 1'b0);

        disp_on = 1'b1;
        dispaddr = 32'h1000_0013;
        repeat (4) @(negedge aclk);
        pin_cap = 1;
        push_frame(dispaddr);
        pulse_start();
        wait_done("frame1_done");
        pin_cap = 0;
        chk("pin_ar0", pin_ar[0], 32'h1000_0000);
        chk("pin_ar1", pin_ar[1], 32'h1000_0020);
        chk("pin_px0", pin_px[0], 24'hA5A5A5);
        chk("pin_px1", pin_px[1], 24'hA5A5A4);
        chk("frame1_pixels", wr_total, 64);
        chk("frame1_bursts", ar_total, 8);

        stall_at = 1;
        bp_at = 3;
        dispaddr = 32'h2000_0040;
        push_frame(dispaddr);
        pulse_start();
        wait_done("frame_bp_done");
        stall_at = -1;
        bp_at = -1;
        chk("bp_pixels", wr_total, 128);

        rand_mode = 1;
        for (int f = 0; f < 4; f++) begin
            dispaddr = $urandom;
            push_frame(dispaddr);
            pulse_start();
            wait_done("rand_frame_done");
        end

        disp_on = 1'b0;
        repeat (4) @(negedge aclk);
        ar_before = ar_total;
        pulse_start();
        repeat (40) @(negedge aclk);
        chk("gated_no_ar", ar_total, ar_before);
        chk("gated_not_busy", busy, 1'b0);
        disp_on = 1'b1;
        repeat (4) @(negedge aclk);

        wr_before = wr_total;
        dispaddr = $urandom;
        push_frame(dispaddr);
        pulse_start();
        n = 0;
        while (frame_ar_idx < 3 && n < 2000) begin
            @(negedge aclk);
            n++;
        end
        chk("overlap_reach_burst3", n < 2000, 1'b1);
        pulse_start();
        wait_done("overlap_done");
        repeat (40) @(negedge aclk);
        chk("overlap_total_pix", wr_total - wr_before, NPIX);
        chk("overlap_no_extra_ar", exp_ar.size(), 0);

        err_req = 1;
        dispaddr = $urandom;
        push_frame(dispaddr);
        pulse_start();
        wait_done("err_frame_done");
        chk("rd_err_set", rd_err, 1'b1);
        dispaddr = $urandom;
        push_frame(dispaddr);
        pulse_start();
        wait_done("err_sticky_frame_done");
        chk("rd_err_sticky", rd_err, 1'b1);

        dispaddr = $urandom;
        push_frame(dispaddr);
        pulse_start();
        n = 0;
        while (!(rready && frame_beats_left < NPIX - 10) && n < 3000) begin
            @(negedge aclk);
            n++;
        end
        chk("reach_mid_data", n < 3000, 1'b1);
        #2 aresetn = 1'b0;
        #1;
        chk("async_arvalid", arvalid, 1'b0);
        chk("async_rready", rready, 1'b0);
        chk("async_fifo_wr", fifo_wr, 1'b0);
        chk("async_fifo_din", fifo_din, 24'h0);
        chk("async_busy", busy, 1'b0);
        chk("async_rd_err", rd_err, 1'b0);
        chk("async_araddr", araddr, 32'h0);
        exp_ar.delete();
        exp_pix.delete();
        frame_beats_left = 0;
        err_model = 0;
        repeat (3) @(negedge aclk);
        aresetn = 1'b1;
        ar_before = ar_total;
        repeat (30) @(negedge aclk);
        chk("post_reset_no_ar", ar_total, ar_before);
        chk("post_reset_idle", busy, 1'b0);

        dispaddr = $urandom;
        push_frame(dispaddr);
        pulse_start();
        wait_done("post_reset_frame_done");
        chk("post_reset_rd_err", rd_err, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog simulation did not complete t=%0t", $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
